// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types and limits for VC credit tracking.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvh_noc_pkg;

    localparam int VC_ID_NUM_MAX   = 6;
    localparam int VC_ID_NUM_MAX_W = 3;

    // Counter storage is sized for the deepest VC buffer any router uses;
    // each slice only exposes the low CNT_W bits.
    localparam int VC_CNT_MAX_W = 8;

    typedef struct packed {
        logic                    busy;
        logic [VC_CNT_MAX_W-1:0] cnt;
    } vc_credit_state_t;

endpackage

// File: rtl/vc_credit_slice.sv
// One downstream VC: saturating credit counter plus packet-busy flag.
// Latency: dec/inc seen at a clock edge are reflected in cnt_o right after it.
// Backpressure: none; saturates at 0 and VC_DEPTH. Error tap under RVH_NOC_CREDIT_CHECK_EN.
module vc_credit_slice
    import rvh_noc_pkg::*;
#(
    parameter int VC_DEPTH = 4,
    parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dec,
    input  logic             inc,
    input  logic             head,
    input  logic             tail,
    output logic [CNT_W-1:0] cnt_o,
    output logic             avail_o,
    output logic             free_o
`ifdef RVH_NOC_CREDIT_CHECK_EN
    ,
    output logic             err_o
`endif
);

    localparam logic [VC_CNT_MAX_W-1:0] DEPTH_C = VC_CNT_MAX_W'(VC_DEPTH);
    localparam logic [VC_CNT_MAX_W-1:0] ONE_C   = VC_CNT_MAX_W'(1);

    vc_credit_state_t state_q;
    vc_credit_state_t state_d;

    logic cnt_zero;
    logic cnt_full;

    assign cnt_zero = (state_q.cnt == '0);
    assign cnt_full = (state_q.cnt == DEPTH_C);

    // Next count and busy: simultaneous dec/inc cancel, tail wins over head.
    always_comb begin
        state_d = state_q;
        if (dec && !inc && !cnt_zero) begin
            state_d.cnt = state_q.cnt - ONE_C;
        end else if (inc && !dec && !cnt_full) begin
            state_d.cnt = state_q.cnt + ONE_C;
        end
        if (dec && tail) begin
            state_d.busy = 1'b0;
        end else if (dec && head) begin
            state_d.busy = 1'b1;
        end
    end

    // State register; reset restores full credit and an idle VC.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q.busy <= 1'b0;
            state_q.cnt  <= DEPTH_C;
        end else begin
            state_q <= state_d;
        end
    end

    assign cnt_o   = state_q.cnt[CNT_W-1:0];
    assign avail_o = !cnt_zero;
    assign free_o  = !state_q.busy && cnt_full;

`ifdef RVH_NOC_CREDIT_CHECK_EN
    assign err_o = (dec && cnt_zero) || (inc && !dec && cnt_full) || (dec && head && state_q.busy);
`endif

endmodule

// File: rtl/output_port_vc_credit_manager.sv
// Per-outport downstream VC credit/busy tracker feeding the VC allocator.
// Latency: consume -> cnt 1 cycle; credit return -> cnt 2 cycles (return is registered).
// Backpressure: none; out-of-range ids ignored. Optional sticky error: RVH_NOC_CREDIT_CHECK_EN.
module output_port_vc_credit_manager
    import rvh_noc_pkg::*;
#(
    parameter int VC_NUM   = 4,
    parameter int VC_DEPTH = 4,
    parameter int VC_ID_W  = VC_ID_NUM_MAX_W,
    parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    consume_vc_credit_vld_i,
    input  logic [VC_ID_W-1:0]      consume_vc_credit_vc_id_i,
    input  logic                    consume_is_head_i,
    input  logic                    consume_is_tail_i,
    input  logic                    credit_return_vld_i,
    input  logic [VC_ID_W-1:0]      credit_return_vc_id_i,
    output logic [VC_NUM*CNT_W-1:0] vc_credit_cnt_o,
    output logic [VC_NUM-1:0]       vc_credit_avail_o,
    output logic [VC_NUM-1:0]       vc_free_o,
    output logic                    credit_err_o
);

    logic               ret_vld_q;
    logic [VC_ID_W-1:0] ret_id_q;

    // Register the credit return so the counter update never sees the link directly.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ret_vld_q <= 1'b0;
            ret_id_q  <= '0;
        end else begin
            ret_vld_q <= credit_return_vld_i;
            ret_id_q  <= credit_return_vc_id_i;
        end
    end

`ifdef RVH_NOC_CREDIT_CHECK_EN
    logic [VC_NUM-1:0] slice_err;
`endif

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic dec;
        logic inc;

        assign dec = consume_vc_credit_vld_i && (consume_vc_credit_vc_id_i == VC_ID_W'(v));
        assign inc = ret_vld_q && (ret_id_q == VC_ID_W'(v));

        vc_credit_slice #(
            .VC_DEPTH (VC_DEPTH),
            .CNT_W    (CNT_W)
        ) u_slice (
            .clk     (clk),
            .rstn    (rstn),
            .dec     (dec),
            .inc     (inc),
            .head    (consume_is_head_i),
            .tail    (consume_is_tail_i),
            .cnt_o   (vc_credit_cnt_o[v*CNT_W +: CNT_W]),
            .avail_o (vc_credit_avail_o[v]),
            .free_o  (vc_free_o[v])
`ifdef RVH_NOC_CREDIT_CHECK_EN
            ,
            .err_o   (slice_err[v])
`endif
        );
    end

`ifdef RVH_NOC_CREDIT_CHECK_EN
    logic id_err;
    logic err_q;

    assign id_err = (consume_vc_credit_vld_i && (consume_vc_credit_vc_id_i >= VC_ID_W'(VC_NUM)))
                 || (ret_vld_q && (ret_id_q >= VC_ID_W'(VC_NUM)));

    // Sticky protocol error: once set, held until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (id_err || (|slice_err)) begin
            err_q <= 1'b1;
        end
    end

    assign credit_err_o = err_q;
`else
    assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_vc_credit_manager.sv
// Randomized + directed bench for output_port_vc_credit_manager against a behavioural model.
// Latency: model applies consume at the edge it is seen, returns one edge later.
// Backpressure: n/a.
module tb_output_port_vc_credit_manager;

    localparam int VC_NUM   = 4;
    localparam int VC_DEPTH = 4;
    localparam int VC_ID_W  = 3;
    localparam int CNT_W    = 3;

`ifdef RVH_NOC_CREDIT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    c_vld;
    logic [VC_ID_W-1:0]      c_id;
    logic                    c_head;
    logic                    c_tail;
    logic                    r_vld;
    logic [VC_ID_W-1:0]      r_id;
    logic [VC_NUM*CNT_W-1:0] cnt;
    logic [VC_NUM-1:0]       avail;
    logic [VC_NUM-1:0]       free;
    logic                    err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state: plain integers per VC, plus the one in-flight return.
    int m_cnt  [VC_NUM];
    bit m_busy [VC_NUM];
    bit m_pend_vld;
    int m_pend_id;
    bit m_err;

    always #5 clk = ~clk;

    output_port_vc_credit_manager #(
        .VC_NUM   (VC_NUM),
        .VC_DEPTH (VC_DEPTH),
        .VC_ID_W  (VC_ID_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .consume_vc_credit_vld_i   (c_vld),
        .consume_vc_credit_vc_id_i (c_id),
        .consume_is_head_i         (c_head),
        .consume_is_tail_i         (c_tail),
        .credit_return_vld_i       (r_vld),
        .credit_return_vc_id_i     (r_id),
        .vc_credit_cnt_o           (cnt),
        .vc_credit_avail_o         (avail),
        .vc_free_o                 (free),
        .credit_err_o              (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently on the bus.
    task automatic model_edge();
        if (!rstn) begin
            for (int v = 0; v < VC_NUM; v++) begin
                m_cnt[v]  = VC_DEPTH;
                m_busy[v] = 1'b0;
            end
            m_pend_vld = 1'b0;
            m_pend_id  = 0;
            m_err      = 1'b0;
        end else begin
            if (c_vld && int'(c_id) >= VC_NUM) m_err = 1'b1;
            if (m_pend_vld && m_pend_id >= VC_NUM) m_err = 1'b1;
            for (int v = 0; v < VC_NUM; v++) begin
                bit d;
                bit i;
                d = c_vld && int'(c_id) == v;
                i = m_pend_vld && m_pend_id == v;
                if (d && m_cnt[v] == 0) m_err = 1'b1;
                if (i && !d && m_cnt[v] == VC_DEPTH) m_err = 1'b1;
                if (d && c_head && m_busy[v]) m_err = 1'b1;
                if (d && !i && m_cnt[v] > 0) m_cnt[v] = m_cnt[v] - 1;
                if (i && !d && m_cnt[v] < VC_DEPTH) m_cnt[v] = m_cnt[v] + 1;
                if (d && c_tail) m_busy[v] = 1'b0;
                else if (d && c_head) m_busy[v] = 1'b1;
            end
            m_pend_vld = r_vld;
            m_pend_id  = int'(r_id);
        end
    endtask

    task automatic check_all(input string tag);
        logic [VC_NUM*CNT_W-1:0] e_cnt;
        logic [VC_NUM-1:0]       e_av;
        logic [VC_NUM-1:0]       e_fr;
        for (int v = 0; v < VC_NUM; v++) begin
            e_cnt[v*CNT_W +: CNT_W] = CNT_W'(m_cnt[v]);
            e_av[v] = m_cnt[v] > 0;
            e_fr[v] = !m_busy[v] && m_cnt[v] == VC_DEPTH;
        end
        chk({tag, "_cnt"},   32'(cnt),   32'(e_cnt));
        chk({tag, "_avail"}, 32'(avail), 32'(e_av));
        chk({tag, "_free"},  32'(free),  32'(e_fr));
        chk({tag, "_err"},   32'(err),   32'(ERR_EN ? m_err : 1'b0));
    endtask

    task automatic step(input string tag, input bit cv, input int cid, input bit hd, input bit tl,
                        input bit rv, input int rid);
        c_vld  = cv;
        c_id   = VC_ID_W'(cid);
        c_head = hd;
        c_tail = tl;
        r_vld  = rv;
        r_id   = VC_ID_W'(rid);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic int cnt_of(input int v);
        return int'(cnt[v*CNT_W +: CNT_W]);
    endfunction

    initial begin
        logic [VC_NUM*CNT_W-1:0] snap;
        rstn = 1'b0;
        c_vld = 0; c_id = 0; c_head = 0; c_tail = 0; r_vld = 0; r_id = 0;
        #2;
        step("rst", 0, 0, 0, 0, 0, 0);
        step("rst", 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        chk("rst_cnt_const",   32'(cnt),   32'h924);
        chk("rst_avail_const", 32'(avail), 32'hf);
        chk("rst_free_const",  32'(free),  32'hf);
        chk("rst_err_const",   32'(err),   32'h0);

        // Four head (non-tail) consumes on VC2 back to back.
        for (int k = 0; k < 4; k++) begin
            step("vc2_drain", 1, 2, 1, 0, 0, 0);
            chk("vc2_drain_cnt",   cnt_of(2),  3 - k);
            chk("vc2_drain_free",  32'(free[2]), 0);
            chk("vc2_drain_avail", 32'(avail[2]), (k < 3) ? 1 : 0);
        end

        // Bring VC1 to 2 with single-flit packets, then cancel a return against a consume.
        step("vc1_pre", 1, 1, 1, 1, 0, 0);
        step("vc1_pre", 1, 1, 1, 1, 0, 0);
        chk("vc1_pre_cnt", cnt_of(1), 2);
        step("vc1_ret", 0, 0, 0, 0, 1, 1);
        step("vc1_both", 1, 1, 1, 1, 0, 0);
        chk("vc1_cancel_cnt", cnt_of(1), 2);
        step("vc1_idle", 0, 0, 0, 0, 0, 0);
        chk("vc1_hold_cnt", cnt_of(1), 2);

        // Return into a full VC0: saturates, flags overflow when checking is built in.
        step("vc0_ovf", 0, 0, 0, 0, 1, 0);
        step("vc0_ovf", 0, 0, 0, 0, 0, 0);
        chk("vc0_ovf_cnt", cnt_of(0), 4);
        chk("vc0_ovf_err", 32'(err), 32'(ERR_EN));

        // Multi-flit packet on VC3, then credits come home.
        step("vc3_head", 1, 3, 1, 0, 0, 0);
        step("vc3_body", 1, 3, 0, 0, 0, 0);
        step("vc3_body", 1, 3, 0, 0, 0, 0);
        step("vc3_tail", 1, 3, 0, 1, 0, 0);
        chk("vc3_tail_cnt", cnt_of(3), 0);
        for (int k = 0; k < 4; k++) step("vc3_ret", 0, 0, 0, 0, 1, 3);
        chk("vc3_ret_free_early", 32'(free[3]), 0);
        step("vc3_ret", 0, 0, 0, 0, 0, 0);
        chk("vc3_ret_cnt", cnt_of(3), 4);
        chk("vc3_ret_free", 32'(free[3]), 1);

        // Out-of-range id: nothing moves.
        rstn = 1'b0;
        step("rst2", 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        chk("rst2_err", 32'(err), 0);
        snap = cnt;
        step("bad_id", 1, 5, 1, 0, 0, 0);
        chk("bad_id_cnt", 32'(cnt), 32'(snap));
        chk("bad_id_err", 32'(err), 32'(ERR_EN));

        // Random traffic, including bad ids and occasional mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            int cid;
            int rid;
            cid = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            rid = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            rstn = ($urandom_range(0, 199) != 0);
            step("rand", 1'($urandom_range(0, 1)), cid, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rid);
        end
        rstn = 1'b1;

        // Reset with a return pending: it must be discarded.
        step("pend", 1, 0, 1, 1, 1, 0);
        rstn = 1'b0;
        step("pend_rst", 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        step("pend_after", 0, 0, 0, 0, 0, 0);
        chk("pend_after_cnt", 32'(cnt), 32'h924);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
